// File: rtl/cfg_write_arbiter.sv
// Two-requester write arbiter for the PWM configuration register bank, with a
// bounded exclusive lock for requester B and a one-stage range-checked commit.
module cfg_write_arbiter #(
  parameter logic [6:0] MAX_ADDRESS = 7'h04,
  parameter int         MAX_LOCK    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  input  logic       b_lock,
  output logic       b_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       lock_active,
  output logic       wr_err,
  output logic [7:0] wr_count
);

  localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK);

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

  rr_t        rr, rr_nxt;
  logic [3:0] lock_cnt, lock_cnt_nxt;
  logic       a_win, b_win;
  logic       stg_valid;
  logic [6:0] stg_addr;
  logic [7:0] stg_data;
  logic       stg_in_range;

  assign lock_active = (lock_cnt != 4'd0);

  // Handshake: a beat transfers when valid && ready on a rising edge. Ready is
  // a combinational function of both valids, rr and the registered lock, so a
  // requester must never make its valid depend on its ready.
  always_comb begin
    a_win = a_valid && !lock_active && (!b_valid || rr == RR_A);
    b_win = b_valid && (lock_active || !a_valid || rr == RR_B);
  end

  assign a_ready = a_win;
  assign b_ready = b_win;

  always_comb begin
    rr_nxt       = rr;
    lock_cnt_nxt = lock_cnt;
    if (a_win) begin
      rr_nxt = RR_B;
    end else if (b_win) begin
      rr_nxt = RR_A;
    end
    // Release wins over any rr update; a B beat in the last lock cycle still lands.
    if (lock_active) begin
      if (!b_lock || lock_cnt == LOCK_LAST) begin
        lock_cnt_nxt = 4'd0;
        rr_nxt       = RR_A;
      end else begin
        lock_cnt_nxt = lock_cnt + 4'd1;
      end
    end else if (b_win && b_lock) begin
      lock_cnt_nxt = 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= RR_A;
      lock_cnt <= 4'd0;
    end else begin
      rr       <= rr_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_addr  <= 7'h00;
      stg_data  <= 8'h00;
    end else begin
      stg_valid <= a_win || b_win;
      stg_addr  <= a_win ? a_addr : b_addr;
      stg_data  <= a_win ? a_data : b_data;
    end
  end

  assign stg_in_range = (stg_addr <= MAX_ADDRESS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      wr_err          <= 1'b0;
      wr_count        <= 8'h00;
    end else begin
      wr_err <= stg_valid && !stg_in_range;
      if (stg_valid && stg_in_range) begin
        wr_count <= wr_count + 8'd1;
        case (stg_addr)
          7'h00:   en_reg_out_7_0  <= stg_data;
          7'h01:   en_reg_out_15_8 <= stg_data;
          7'h02:   en_reg_pwm_7_0  <= stg_data;
          7'h03:   en_reg_pwm_15_8 <= stg_data;
          7'h04:   pwm_duty_cycle  <= stg_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter: accepted beats are checked in order
// against an expected queue by a monitor; register state is checked directly.
module tb_cfg_write_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid, b_lock;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle, wr_count;
  logic       lock_active, wr_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {src (0=A, 1=B), addr, data} of each beat expected to be accepted, in order
  logic [15:0] exp_q[$];
  logic [14:0] a_q[$];
  logic [14:0] b_q[$];

  cfg_write_arbiter #(.MAX_ADDRESS(7'h04), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_lock(b_lock),
    .b_ready(b_ready),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .lock_active(lock_active),
    .wr_err(wr_err), .wr_count(wr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_regs(input string tag, input logic [39:0] exp_regs, input logic [7:0] exp_cnt);
    check({tag, "_r0"}, 32'(en_reg_out_7_0),  32'(exp_regs[7:0]));
    check({tag, "_r1"}, 32'(en_reg_out_15_8), 32'(exp_regs[15:8]));
    check({tag, "_r2"}, 32'(en_reg_pwm_7_0),  32'(exp_regs[23:16]));
    check({tag, "_r3"}, 32'(en_reg_pwm_15_8), 32'(exp_regs[31:24]));
    check({tag, "_r4"}, 32'(pwm_duty_cycle),  32'(exp_regs[39:32]));
    check({tag, "_wr_count"}, 32'(wr_count),  32'(exp_cnt));
  endtask

  task automatic mon_accept(input logic [15:0] got);
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL accept_unexpected: got 0x%0h expected no accept at %0t", got, $time);
    end else begin
      check("accept_order", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // monitor: samples handshakes mid-cycle, before the accepting edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (a_valid && a_ready && b_valid && b_ready) begin
          total_cnt++;
          $display("FAIL one_accept: got 2 accepts expected 1 at %0t", $time);
        end
        if (a_valid && a_ready) mon_accept({1'b0, a_addr, a_data});
        if (b_valid && b_ready) mon_accept({1'b1, b_addr, b_data});
      end
    end
  end

  // driver: presents queued beats, advances each queue on its own handshake
  task automatic run_beats(input int budget);
    int  n = 0;
    logic fa, fb;
    while ((a_q.size() + b_q.size()) != 0 && n < budget) begin
      a_valid = (a_q.size() != 0);
      b_valid = (b_q.size() != 0);
      if (a_valid) {a_addr, a_data} = a_q[0];
      if (b_valid) {b_addr, b_data} = b_q[0];
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      @(posedge clk); #1;
      if (fa) void'(a_q.pop_front());
      if (fb) void'(b_q.pop_front());
      n++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("drain_budget", 32'(a_q.size() + b_q.size()), 32'd0);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0; b_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset", 40'h0, 8'h00);
    check("reset_lock_active", 32'(lock_active), 32'd0);
    check("reset_wr_err", 32'(wr_err), 32'd0);
    rst = 1'b0;

    // round robin: both valid, rr starts at A
    a_q = '{{7'h00, 8'h11}, {7'h01, 8'h22}, {7'h00, 8'h33}, {7'h02, 8'h44}};
    b_q = '{{7'h01, 8'h55}, {7'h03, 8'h66}, {7'h00, 8'h77}, {7'h03, 8'h88}};
    exp_q = '{{1'b0, 7'h00, 8'h11}, {1'b1, 7'h01, 8'h55}, {1'b0, 7'h01, 8'h22},
              {1'b1, 7'h03, 8'h66}, {1'b0, 7'h00, 8'h33}, {1'b1, 7'h00, 8'h77},
              {1'b0, 7'h02, 8'h44}, {1'b1, 7'h03, 8'h88}};
    run_beats(40);
    @(posedge clk); #1;
    check_regs("rr", {8'h00, 8'h88, 8'h44, 8'h22, 8'h77}, 8'd8);

    // single write lands one cycle after the accept
    a_q.push_back({7'h04, 8'h80});
    exp_q.push_back({1'b0, 7'h04, 8'h80});
    run_beats(10);
    @(posedge clk); #1;
    check_regs("single", {8'h80, 8'h88, 8'h44, 8'h22, 8'h77}, 8'd9);
    check("single_wr_err", 32'(wr_err), 32'd0);

    // two consecutive out-of-range beats
    a_q = '{{7'h05, 8'hFF}, {7'h7F, 8'h01}};
    exp_q.push_back({1'b0, 7'h05, 8'hFF});
    exp_q.push_back({1'b0, 7'h7F, 8'h01});
    run_beats(10);
    check("bad_wr_err_1", 32'(wr_err), 32'd1);
    @(posedge clk); #1;
    check("bad_wr_err_2", 32'(wr_err), 32'd1);
    @(posedge clk); #1;
    check("bad_wr_err_end", 32'(wr_err), 32'd0);
    check_regs("bad", {8'h80, 8'h88, 8'h44, 8'h22, 8'h77}, 8'd9);

    // lock held to MAX_LOCK; rr favours B here so B starts the lock
    a_valid = 1'b1; a_addr = 7'h00; a_data = 8'hAA;
    b_valid = 1'b1; b_addr = 7'h02; b_data = 8'hB1; b_lock = 1'b1;
    exp_q.push_back({1'b1, 7'h02, 8'hB1});
    @(negedge clk);
    check("lock_pre_active", 32'(lock_active), 32'd0);
    @(posedge clk); #1;
    b_addr = 7'h03; b_data = 8'hB2;
    exp_q.push_back({1'b1, 7'h03, 8'hB2});
    @(negedge clk);
    check("lock_c1_active", 32'(lock_active), 32'd1);
    check("lock_c1_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_hold_active", 32'(lock_active), 32'd1);
      check("lock_hold_a_ready", 32'(a_ready), 32'd0);
      @(posedge clk); #1;
    end
    exp_q.push_back({1'b0, 7'h00, 8'hAA});
    @(negedge clk);
    check("lock_rel_active", 32'(lock_active), 32'd0);
    check("lock_rel_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_lock = 1'b0;
    @(posedge clk); #1;
    check_regs("lock", {8'h80, 8'hB2, 8'hB1, 8'h22, 8'hAA}, 8'd12);

    // early release when b_lock drops
    a_valid = 1'b1; a_addr = 7'h01; a_data = 8'hC1;
    b_valid = 1'b1; b_addr = 7'h04; b_data = 8'hC2; b_lock = 1'b1;
    exp_q.push_back({1'b1, 7'h04, 8'hC2});
    @(posedge clk); #1;
    b_valid = 1'b0; b_lock = 1'b0;
    @(negedge clk);
    check("drop_c1_active", 32'(lock_active), 32'd1);
    check("drop_c1_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 7'h01, 8'hC1});
    @(negedge clk);
    check("drop_rel_active", 32'(lock_active), 32'd0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    check_regs("drop", {8'hC2, 8'hB2, 8'hB1, 8'hC1, 8'hAA}, 8'd14);

    // timeout: B locks then goes idle; A waits MAX_LOCK locked cycles
    b_valid = 1'b1; b_addr = 7'h01; b_data = 8'hD1; b_lock = 1'b1;
    exp_q.push_back({1'b1, 7'h01, 8'hD1});
    @(posedge clk); #1;
    b_valid = 1'b0;
    a_valid = 1'b1; a_addr = 7'h02; a_data = 8'hD2;
    exp_q.push_back({1'b0, 7'h02, 8'hD2});
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!a_ready && waited < 12);
    check("timeout_cycles", 32'(waited), 32'd5);
    @(posedge clk); #1;
    a_valid = 1'b0; b_lock = 1'b0;
    @(posedge clk); #1;
    check("timeout_lock_active", 32'(lock_active), 32'd0);
    check_regs("timeout", {8'hC2, 8'hB2, 8'hD2, 8'hD1, 8'hAA}, 8'd16);

    // asynchronous reset mid-lock discards the staged beat
    b_valid = 1'b1; b_addr = 7'h00; b_data = 8'hEE; b_lock = 1'b1;
    exp_q.push_back({1'b1, 7'h00, 8'hEE});
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("rst_pre_lock_active", 32'(lock_active), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_regs("async_rst", 40'h0, 8'h00);
    check("async_rst_lock_active", 32'(lock_active), 32'd0);
    check("async_rst_wr_err", 32'(wr_err), 32'd0);
    b_lock = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_regs("post_rst", 40'h0, 8'h00);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cfg_write_arbiter.md
# cfg_write_arbiter

Arbitrates write access to the PWM configuration register bank between two requesters. Requester A is the SPI command decoder; requester B is the on-chip sequencer. The block owns the five configuration registers that drive the output-enable and PWM blocks. Accepted writes pass through a one-stage commit pipeline with address range checking. Requester B can lock the bank for a bounded window so that multi-register updates land atomically.

## Interface
Parameters:
- MAX_ADDRESS, 7'h04: highest writable register address.
- MAX_LOCK, 4: maximum lock window in clock cycles. Legal range 1..15.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- a_valid  in  1  requester A write beat valid.
- a_addr  in  7  requester A register address.
- a_data  in  8  requester A write data.
- a_ready  out  1  requester A beat accepted this cycle.
- b_valid  in  1  requester B write beat valid.
- b_addr  in  7  requester B register address.
- b_data  in  8  requester B write data.
- b_lock  in  1  requester B requests or holds exclusive access.
- b_ready  out  1  requester B beat accepted this cycle.
- en_reg_out_7_0  out  8  register at address 0x00.
- en_reg_out_15_8  out  8  register at address 0x01.
- en_reg_pwm_7_0  out  8  register at address 0x02.
- en_reg_pwm_15_8  out  8  register at address 0x03.
- pwm_duty_cycle  out  8  register at address 0x04.
- lock_active  out  1  B currently holds the lock.
- wr_err  out  1  one-cycle pulse when a committed beat had an address above MAX_ADDRESS.
- wr_count  out  8  number of successful register writes, wraps 255 -> 0.

## Operation
- Valid/ready handshake. A beat transfers in any cycle where valid and ready are both high.
- a_ready and b_ready are combinational from valid, the rr pointer and lock state. Requesters must not make valid depend on ready.
- At most one beat is accepted per cycle.
- Arbitration, in priority order:
  - If lock_active: only B can win. a_ready is 0 even if B is idle.
  - Else if only one requester is valid: that requester wins.
  - Else if both are valid: the rr pointer selects the winner. After each accept, rr points to the other requester.
- rr resets to favor A.
- Lock state:
  - lock_cnt is 4 bits; lock_active = (lock_cnt != 0).
  - Lock starts on a B accept with b_lock=1 while not locked; lock_cnt becomes 1.
  - While locked, lock_cnt increments every cycle.
  - Lock ends (lock_cnt goes to 0, rr forced to A) on whichever comes first:
    - any cycle with lock_active=1 and b_lock=0;
    - the edge where lock_cnt reaches MAX_LOCK.
  - A B beat accepted in the final lock cycle is still accepted.
- Commit stage registers the accepted beat (stg_valid, stg_addr, stg_data).
  - If stg_addr <= MAX_ADDRESS: write the decoded register and increment wr_count.
  - Otherwise: leave all registers unchanged and pulse wr_err.
- Registers are written only through the commit stage. There are no other write paths.

## Timing
- Reset (async assert): all five registers = 0x00, wr_count = 0, wr_err = 0, lock_cnt = 0, lock_active = 0, stg_valid = 0, rr = A. Any staged write is discarded.
- Reset release: first possible accept is on the first rising edge with rst low.
- Latency:
  - Beat accepted at edge N lands in the commit stage at edge N.
  - Register value, wr_count and wr_err update at edge N+1, visible during cycle N+1.
- Throughput: one write per cycle, sustained. Back-to-back writes to the same address: the last one wins.
- wr_err is high for exactly one cycle per bad beat. Consecutive bad beats give consecutive high cycles.
- lock_active is registered and rises the cycle after the locking accept. The arbitration gate uses the registered value.
- B may deassert b_valid inside the lock window. The lock persists, and A stays blocked, until release.
- Reset mid-lock clears the lock immediately.

## Test plan
- Reset: assert rst mid-operation -> all registers 0x00, wr_count 0, lock_active 0 asynchronously, before the next clk edge.
- Single write: A writes addr 0x04 data 0x80 -> a_ready high in the valid cycle; pwm_duty_cycle = 0x80 one cycle later; wr_count = 1.
- Round-robin: A and B both valid continuously, 4 beats each -> acceptance order A,B,A,B,...; final register values match the last beat of each address.
- Out of range: A writes addr 0x05 data 0xFF -> wr_err pulses 1 cycle; all registers unchanged; wr_count unchanged.
- Lock with MAX_LOCK=4: B holds b_lock=1 and writes 0x02 then 0x03 while A is valid -> A blocked until release; a_ready rises the cycle after lock_cnt reaches 4, or earlier if b_lock drops.
- Lock timeout: B holds b_lock=1 with b_valid=0 and A valid -> A is accepted within MAX_LOCK+1 cycles of lock start; lock_active is 0 afterward.
